// File: rtl/cfg_ram_arb_pkg.sv
// Shared types and constants for the cfg_ram_arbiter slice.
package cfg_ram_arb_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } arb_state_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/cfg_ram_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// pointer moves past the winner only when advance is high.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] r_ptr;
  logic          w_found;
  int            w_j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < N; k++) begin
      w_j = (int'(r_ptr) + k) % N;
      if (!w_found && req[w_j]) begin
        w_found    = 1'b1;
        gnt[w_j]   = 1'b1;
        gnt_idx    = IW'(w_j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance && w_found) begin
      r_ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/cfg_ram_arbiter.sv
// Shares one 1W/1R RAM between NUM_REQ requesters after a zero-fill phase.
// Optional per-requester grant counters: define CFG_RAM_ARB_STATS_EN.
module cfg_ram_arbiter
  import cfg_ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [WIDTH-1:0]              rsp_rdata,
  output logic                          init_done,
  output logic                          ram_wr_en,
  output logic [ADDR_WIDTH-1:0]         ram_wr_addr,
  output logic [WIDTH-1:0]              ram_wr_data,
  output logic                          ram_rd_en,
  output logic [ADDR_WIDTH-1:0]         ram_rd_addr,
  input  logic [WIDTH-1:0]              ram_rd_data
`ifdef CFG_RAM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]     stat_grants
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e              r_state;
  arb_state_e              w_stateNext;
  logic [ADDR_WIDTH-1:0]   r_initCnt;
  logic [NUM_REQ-1:0]      r_rspValid;
  logic                    w_run;
  logic [NUM_REQ-1:0]      w_wrCand;
  logic [NUM_REQ-1:0]      w_rdCand;
  logic [NUM_REQ-1:0]      w_wrGnt;
  logic [NUM_REQ-1:0]      w_rdGnt;
  logic [NUM_REQ-1:0]      w_rdAcc;
  logic [IW-1:0]           w_wrIdx;
  logic [IW-1:0]           w_rdIdx;
  logic                    w_wrAny;
  logic                    w_rdAny;
  logic                    w_hazard;
  logic [ADDR_WIDTH-1:0]   w_wrAddr;
  logic [ADDR_WIDTH-1:0]   w_rdAddr;
  logic [WIDTH-1:0]        w_wrData;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_INIT;
      r_initCnt <= '0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == ST_INIT) begin
        r_initCnt <= r_initCnt + ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_INIT: if (r_initCnt == ADDR_WIDTH'(DEPTH - 1)) w_stateNext = ST_RUN;
      ST_RUN:  w_stateNext = ST_RUN;
      default: w_stateNext = ST_INIT;
    endcase
  end

  assign w_run    = (r_state == ST_RUN);
  assign w_wrCand = req_valid & req_we & {NUM_REQ{w_run}};
  assign w_rdCand = req_valid & ~req_we & {NUM_REQ{w_run}};

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_wrArb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_wrCand),
    .advance (1'b1),
    .gnt     (w_wrGnt),
    .gnt_idx (w_wrIdx)
  );

  // A read colliding with this cycle's write is held off so its pointer stays put.
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rdArb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_rdCand),
    .advance (!w_hazard),
    .gnt     (w_rdGnt),
    .gnt_idx (w_rdIdx)
  );

  assign w_wrAny  = |w_wrGnt;
  assign w_rdAny  = |w_rdGnt;
  assign w_wrAddr = req_addr[w_wrIdx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_rdAddr = req_addr[w_rdIdx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_wrData = req_wdata[w_wrIdx*WIDTH +: WIDTH];
  assign w_hazard = w_wrAny && w_rdAny && (w_wrAddr == w_rdAddr);
  assign w_rdAcc  = w_hazard ? '0 : w_rdGnt;

  assign ram_wr_en   = w_run ? w_wrAny  : 1'b1;
  assign ram_wr_addr = w_run ? w_wrAddr : r_initCnt;
  assign ram_wr_data = w_run ? w_wrData : '0;
  assign ram_rd_en   = w_rdAny && !w_hazard;
  assign ram_rd_addr = w_rdAddr;
  assign req_ready   = w_wrGnt | w_rdAcc;
  assign rsp_valid   = r_rspValid;
  assign rsp_rdata   = ram_rd_data;
  assign init_done   = w_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rspValid <= '0;
    end else begin
      r_rspValid <= w_rdAcc;
    end
  end

`ifdef CFG_RAM_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat     [NUM_REQ];
  logic [STAT_W-1:0] w_statNext [NUM_REQ];
  logic [STAT_W:0]   w_sum;

  // Read and write accepted together for one requester count as two grants.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_stat[i]} + (STAT_W+1)'(w_wrGnt[i]) + (STAT_W+1)'(w_rdAcc[i]);
      w_statNext[i] = w_sum[STAT_W] ? '1 : w_sum[STAT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        r_stat[i] <= '0;
      end else begin
        r_stat[i] <= w_statNext[i];
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_grants[i*STAT_W +: STAT_W] = r_stat[i];
    end
  end
`endif

endmodule

// File: tb/tb_cfg_ram_arbiter.sv
// Scoreboard bench for cfg_ram_arbiter with a behavioural RAM and arbitration model.
module tb_cfg_ram_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_we = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*W-1:0]   req_wdata = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [W-1:0]      rsp_rdata;
  logic              init_done;
  logic              ram_wr_en;
  logic [AW-1:0]     ram_wr_addr;
  logic [W-1:0]      ram_wr_data;
  logic              ram_rd_en;
  logic [AW-1:0]     ram_rd_addr;
  logic [W-1:0]      ram_rd_data;
`ifdef CFG_RAM_ARB_STATS_EN
  logic [NR*16-1:0]  stat_grants;
`endif

  cfg_ram_arbiter #(.NUM_REQ(NR), .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .init_done   (init_done),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
`ifdef CFG_RAM_ARB_STATS_EN
    ,
    .stat_grants (stat_grants)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural simple_ram: registered read, one write port.
  logic [W-1:0] ramMem [D];
  always @(posedge clk) begin
    if (ram_wr_en) ramMem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= ramMem[ram_rd_addr];
  end

  typedef struct {
    int            due;
    logic [NR-1:0] who;
    logic [W-1:0]  data;
  } rsp_t;

  rsp_t          q[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  bit            randomMode = 1'b1;
  logic [NR-1:0] lastAcc = '0;

  logic          pV  [NR];
  logic          pWe [NR];
  logic [AW-1:0] pA  [NR];
  logic [W-1:0]  pD  [NR];

  int            mWrPtr = 0;
  int            mRdPtr = 0;
  logic [W-1:0]  mMem  [D];
  int            mStat [NR];

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every accepted read must answer exactly one cycle later.
  always @(negedge clk) begin
    rsp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      checkOutput("rsp_valid", 64'(rsp_valid), 64'(e.who));
      checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
    end else if (rsp_valid != '0) begin
      checkOutput("rsp_unexpected", 64'(rsp_valid), 64'd0);
    end
  end

  task automatic driveInputs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = pV[i];
      req_we[i]              = pWe[i];
      req_addr[i*AW +: AW]   = pA[i];
      req_wdata[i*W +: W]    = pD[i];
    end
  endtask

  task automatic newReq(input int i);
    pV[i]  = ($urandom_range(0, 3) != 0);
    pWe[i] = 1'($urandom_range(0, 1));
    pA[i]  = AW'($urandom_range(0, 5));
    pD[i]  = $urandom;
  endtask

  task automatic applyStimulus(input int i, input logic v, input logic we,
                               input logic [AW-1:0] a, input logic [W-1:0] d);
    pV[i] = v; pWe[i] = we; pA[i] = a; pD[i] = d;
    driveInputs();
  endtask

  // Reference arbitration for the current cycle, then update model state.
  task automatic evalCycle();
    int wg, rg, j;
    logic [NR-1:0] expRdy;
    #1;
    wg = -1; rg = -1;
    for (int k = 0; k < NR; k++) begin
      j = (mWrPtr + k) % NR;
      if (wg < 0 && pV[j] && pWe[j]) wg = j;
    end
    for (int k = 0; k < NR; k++) begin
      j = (mRdPtr + k) % NR;
      if (rg < 0 && pV[j] && !pWe[j]) rg = j;
    end
    if (wg >= 0 && rg >= 0 && pA[wg] == pA[rg]) rg = -1;
    expRdy = '0;
    if (wg >= 0) expRdy[wg] = 1'b1;
    if (rg >= 0) expRdy[rg] = 1'b1;
    checkOutput("req_ready", 64'(req_ready), 64'(expRdy));
    checkOutput("ram_wr_en", 64'(ram_wr_en), 64'(wg >= 0));
    checkOutput("ram_rd_en", 64'(ram_rd_en), 64'(rg >= 0));
    if (wg >= 0) begin
      checkOutput("ram_wr_addr", 64'(ram_wr_addr), 64'(pA[wg]));
      checkOutput("ram_wr_data", 64'(ram_wr_data), 64'(pD[wg]));
    end
    if (rg >= 0) begin
      checkOutput("ram_rd_addr", 64'(ram_rd_addr), 64'(pA[rg]));
      q.push_back('{due: cyc + 1, who: NR'(1) << rg, data: mMem[pA[rg]]});
      mRdPtr = (rg + 1) % NR;
      mStat[rg]++;
    end
    if (wg >= 0) begin
      mMem[pA[wg]] = pD[wg];
      mWrPtr = (wg + 1) % NR;
      mStat[wg]++;
    end
    lastAcc = expRdy;
  endtask

  task automatic advanceCycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (randomMode) begin
        if (lastAcc[i] || !pV[i]) newReq(i);
      end else if (lastAcc[i]) begin
        pV[i] = 1'b0;
      end
    end
    lastAcc = '0;
    driveInputs();
    @(negedge clk);
  endtask

  task automatic step();
    evalCycle();
    advanceCycle();
  endtask

  // Asserts reset, then follows the zero-fill; abortAt stops early at that address.
  task automatic doReset(input int abortAt);
    rst = 1'b1;
    q.delete();
    mWrPtr = 0; mRdPtr = 0; lastAcc = '0;
    for (int i = 0; i < D; i++) mMem[i] = '0;
    for (int i = 0; i < NR; i++) mStat[i] = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < D; k++) begin
      @(negedge clk);
      checkOutput("init_wr_en", 64'(ram_wr_en), 64'd1);
      checkOutput("init_wr_addr", 64'(ram_wr_addr), 64'(k));
      checkOutput("init_wr_data", 64'(ram_wr_data), 64'd0);
      checkOutput("init_ready", 64'(req_ready), 64'd0);
      checkOutput("init_done_low", 64'(init_done), 64'd0);
      checkOutput("init_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("init_rd_en", 64'(ram_rd_en), 64'd0);
      if (k == abortAt) return;
    end
    @(negedge clk);
    checkOutput("init_done_high", 64'(init_done), 64'd1);
`ifdef CFG_RAM_ARB_STATS_EN
    checkOutput("stat_cleared", 64'(stat_grants), 64'd0);
`endif
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      newReq(i);
      pV[i] = 1'b1;
    end
    driveInputs();
    doReset(-1);

    randomMode = 1'b0;
    for (int i = 0; i < NR; i++) applyStimulus(i, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < NR; i++) applyStimulus(i, 1'b1, 1'b1, AW'(10 + i), W'(32'h1000 + i));
    for (int n = 0; n < 5; n++) step();

    applyStimulus(1, 1'b1, 1'b1, 4'd5, 32'hA5A5A5A5);
    step();
    applyStimulus(2, 1'b1, 1'b0, 4'd5, '0);
    step();
    step();

    applyStimulus(0, 1'b1, 1'b1, 4'd7, 32'h7777_0007);
    applyStimulus(3, 1'b1, 1'b0, 4'd7, '0);
    for (int n = 0; n < 3; n++) step();

    applyStimulus(0, 1'b1, 1'b1, 4'd3, 32'h3333_0003);
    applyStimulus(1, 1'b1, 1'b0, 4'd9, '0);
    step();
    step();

    for (int i = 0; i < NR; i++) applyStimulus(i, 1'b1, 1'b0, AW'(10 + i), '0);
    for (int n = 0; n < 5; n++) step();

    randomMode = 1'b1;
    for (int n = 0; n < 300; n++) step();

    randomMode = 1'b0;
    for (int i = 0; i < NR; i++) applyStimulus(i, 1'b0, 1'b0, '0, '0);
    applyStimulus(1, 1'b1, 1'b0, 4'd2, '0);
    evalCycle();
    doReset(-1);

    randomMode = 1'b1;
    for (int i = 0; i < NR; i++) newReq(i);
    driveInputs();
    doReset(8);
    doReset(-1);
    for (int n = 0; n < 200; n++) step();

    randomMode = 1'b0;
    for (int i = 0; i < NR; i++) applyStimulus(i, 1'b0, 1'b0, '0, '0);
    step();
    step();
    checkOutput("drain_queue", 64'(q.size()), 64'd0);
`ifdef CFG_RAM_ARB_STATS_EN
    for (int i = 0; i < NR; i++) checkOutput("stat_count", 64'(stat_grants[i*16 +: 16]), 64'(mStat[i]));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cfg_ram_arbiter.md
Name: cfg_ram_arbiter

Overview:
- Shares one simple_ram instance (1 write port + 1 read port, registered read, 1-cycle latency) between NUM_REQ requesters in the CGRA subsystem, e.g. config loader, PE spill and debug access.
- Runs two independent round-robin arbiters, one per RAM port, so one write and one read can be granted each cycle.
- After reset, an init FSM zero-fills the RAM before any requester is served.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, data width; matches the RAM
- DEPTH, 512, RAM words
- ADDR_WIDTH, $clog2(DEPTH), address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at slice i
- req_wdata  in  NUM_REQ*WIDTH  packed write data
- req_ready  out  NUM_REQ  request accepted this cycle
- rsp_valid  out  NUM_REQ  one-hot read-data-valid
- rsp_rdata  out  WIDTH  shared read data; qualified by rsp_valid
- init_done  out  1  high once zero-fill completes
- ram_wr_en  out  1  to RAM wr_en
- ram_wr_addr  out  ADDR_WIDTH  to RAM wr_addr
- ram_wr_data  out  WIDTH  to RAM wr_data
- ram_rd_en  out  1  to RAM rd_en
- ram_rd_addr  out  ADDR_WIDTH  to RAM rd_addr
- ram_rd_data  in  WIDTH  from RAM rd_data

Behaviour:
- Reset values: all req_ready=0, rsp_valid=0, init_done=0, ram_rd_en=0; both RR pointers=0; init counter=0; FSM enters INIT.
- FSM INIT:
  - Each cycle: ram_wr_en=1, ram_wr_addr=counter, ram_wr_data=0; counter increments.
  - After writing DEPTH-1, go to RUN. INIT lasts exactly DEPTH cycles.
  - req_ready=0 throughout INIT.
- FSM RUN:
  - init_done=1; no exit except reset.
  - rst asserted mid-INIT or mid-RUN restarts INIT from address 0 and drops any in-flight rsp_valid.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - req_ready is combinational from req_valid/req_we and arbiter state.
  - Requesters hold valid, we, addr and wdata stable until accepted.
- Write arbiter:
  - Candidates are requesters with valid && we.
  - Grant the first candidate at or after wr_ptr, modulo NUM_REQ.
  - On grant to i: wr_ptr <= (i+1) mod NUM_REQ; ram_wr_* driven combinationally from requester i.
- Read arbiter:
  - Same rule on valid && !we with rd_ptr; drives ram_rd_en/ram_rd_addr.
- Hazard rule: if the chosen read address equals the granted write address in the same cycle:
  - the read is not granted and rd_ptr is unchanged;
  - it retries next cycle, so a read never observes same-cycle write ambiguity.
- Read response:
  - A read granted in cycle T gives rsp_valid one-hot for the granted requester in T+1, with rsp_rdata = ram_rd_data.
  - Back-to-back reads from different requesters give one response per cycle.
- No buffering: responses are unconditional; requesters must always sink rsp_valid.
- Idle: with no candidates, the port enable is 0 and its pointer is unchanged.

Optional Feature:
- Macro: CFG_RAM_ARB_STATS_EN.
- When defined:
  - adds output stat_grants (NUM_REQ*16), one 16-bit counter per requester;
  - each counter increments on every accepted request (read or write) and saturates at 16'hFFFF;
  - a read and a write granted to one requester in the same cycle add 2;
  - counters are cleared by rst and do not count during INIT.
- When undefined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cfg_ram_arb_pkg holds:
  - state enum arb_state_e {ST_INIT, ST_RUN};
  - localparam STAT_W=16.
- One sub-module rr_arbiter (params N; inputs clk, rst, req vector, advance; outputs one-hot gnt and gnt index). It is instantiated twice, for the write and read ports; advance=0 lets the hazard rule suppress the read pointer update.

Test Plan:
- Reset then idle, DEPTH=16 → ram_wr_en=1 for exactly 16 cycles with addrs 0..15 and data 0; init_done rises on cycle 17; req_ready=0 before it.
- After init, all 4 requesters hold write requests → grants rotate 0,1,2,3,0 on consecutive cycles; each slot's wdata lands at its addr.
- Req1 writes addr 5 = 0xA5A5A5A5; next cycle req2 reads addr 5 → rsp_valid=4'b0100 one cycle after grant, rsp_rdata=0xA5A5A5A5.
- Same cycle: req0 writes addr 7, req3 reads addr 7 → write granted, read stalled one cycle, then returns the new data; rd_ptr is unaffected by the stall.
- Simultaneous write by req0 (addr 3) and read by req1 (addr 9) → both granted in one cycle; rsp_valid=4'b0010 next cycle.
- Pulse rst mid-INIT at counter=8, and with a read in flight → INIT restarts at addr 0; no rsp_valid appears; with stats enabled, counters read 0.
